duel_grant_arbiter: RTL and testbench

- Moore-style arbiter that shares one resource between two requesters, P1 and P2.
- Grants are derived only from the registered state.
- Round-robin tie-break on simultaneous requests.
- Each grant is capped by a hold timeout, and a break-before-make gap is forced between grants.
- Sits in front of the shared datapath as its sequencing controller; grant lines gate the datapath enables.

---
 rtl/duel_grant_arbiter.sv | 86 ++++++++
 tb/tb_duel_grant_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/duel_grant_arbiter.sv
// Two-requester Moore arbiter with round-robin tie-break, hold timeout and
// a forced break-before-make gap between consecutive grants.
module duel_grant_arbiter #(
    parameter int MAX_HOLD   = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic P1,
    input  logic P2,
    output logic g1,
    output logic g2,
    output logic busy,
    output logic expired
);

    // state  | meaning
    // IDLE   | no grant, resource free
    // GRANT1 | P1 owns the resource
    // GRANT2 | P2 owns the resource
    // GAP    | dead cycles after a release, no grant
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT1 = 2'd1;
    localparam logic [1:0] GRANT2 = 2'd2;
    localparam logic [1:0] GAP    = 2'd3;

    logic [1:0] state;
    logic [1:0] arb_state;
    logic [7:0] hold_cnt;
    logic [3:0] gap_cnt;
    logic       last;

    // last==1 means P2 was served last, so P1 wins the next tie
    always_comb begin
        arb_state = IDLE;
        if (P1 && (!P2 || last))
            arb_state = GRANT1;
        else if (P2)
            arb_state = GRANT2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= 8'd0;
            gap_cnt  <= 4'd0;
            last     <= 1'b1;
            expired  <= 1'b0;
        end else begin
            expired <= 1'b0;
            case (state)
                GRANT1, GRANT2: begin
                    if ((state == GRANT1) ? !P1 : !P2) begin
                        state   <= GAP;
                        gap_cnt <= 4'd1;
                    end else if (hold_cnt == 8'(MAX_HOLD)) begin
                        state   <= GAP;
                        gap_cnt <= 4'd1;
                        expired <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    if (state == GAP && gap_cnt != 4'(GAP_CYCLES)) begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end else begin
                        state <= arb_state;
                        if (arb_state == GRANT1) begin
                            last     <= 1'b0;
                            hold_cnt <= 8'd1;
                        end else if (arb_state == GRANT2) begin
                            last     <= 1'b1;
                            hold_cnt <= 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign g1   = (state == GRANT1);
    assign g2   = (state == GRANT2);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_duel_grant_arbiter.sv
// Randomised bench for duel_grant_arbiter: two instances (default and
// GAP_CYCLES=2/MAX_HOLD=3) driven in lockstep and compared to a cycle model.
module tb_duel_grant_arbiter;

    logic       clk = 1'b0;
    logic       reset, p1, p2;
    logic [1:0] g1v, g2v, busyv, expv;

    int errors = 0;
    int checks = 0;

    int maxh [2] = '{8, 3};
    int gapc [2] = '{1, 2};

    // model: who owns the resource, how long, and how much gap remains
    int owner    [2];
    int held     [2];
    int gap_left [2];
    bit in_gap   [2];
    bit last_p2  [2];
    bit exp_m    [2];

    always #5 clk = ~clk;

    duel_grant_arbiter u_dut0 (
        .clk(clk), .reset(reset), .P1(p1), .P2(p2),
        .g1(g1v[0]), .g2(g2v[0]), .busy(busyv[0]), .expired(expv[0])
    );

    duel_grant_arbiter #(.MAX_HOLD(3), .GAP_CYCLES(2)) u_dut1 (
        .clk(clk), .reset(reset), .P1(p1), .P2(p2),
        .g1(g1v[1]), .g2(g2v[1]), .busy(busyv[1]), .expired(expv[1])
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic pick(input int k, input bit a, input bit b);
        if (a && (!b || last_p2[k])) begin
            owner[k] = 1; held[k] = 1; last_p2[k] = 1'b0;
        end else if (b) begin
            owner[k] = 2; held[k] = 1; last_p2[k] = 1'b1;
        end
    endtask

    task automatic model_step(input int k, input bit r, input bit a, input bit b);
        bit req;
        if (r) begin
            owner[k] = 0; held[k] = 0; in_gap[k] = 1'b0; last_p2[k] = 1'b1; exp_m[k] = 1'b0;
        end else begin
            exp_m[k] = 1'b0;
            if (owner[k] != 0) begin
                req = (owner[k] == 1) ? a : b;
                if (!req || held[k] == maxh[k]) begin
                    exp_m[k]    = req;
                    owner[k]    = 0;
                    in_gap[k]   = 1'b1;
                    gap_left[k] = gapc[k];
                end else begin
                    held[k]++;
                end
            end else if (in_gap[k]) begin
                gap_left[k]--;
                if (gap_left[k] == 0) begin
                    in_gap[k] = 1'b0;
                    pick(k, a, b);
                end
            end else begin
                pick(k, a, b);
            end
        end
    endtask

    task automatic run_cycle(input bit r, input bit a, input bit b);
        reset = r; p1 = a; p2 = b;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, r, a, b);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("g1[%0d]", k), 8'(g1v[k]), 8'(owner[k] == 1));
            chk($sformatf("g2[%0d]", k), 8'(g2v[k]), 8'(owner[k] == 2));
            chk($sformatf("busy[%0d]", k), 8'(busyv[k]), 8'(owner[k] != 0 || in_gap[k]));
            chk($sformatf("expired[%0d]", k), 8'(expv[k]), 8'(exp_m[k]));
            chk($sformatf("hold_le_max[%0d]", k), 8'(held[k] <= maxh[k] && !(g1v[k] && g2v[k])), 8'd1);
        end
        @(negedge clk);
    endtask

    initial begin
        bit a, b;
        for (int k = 0; k < 2; k++) begin
            owner[k] = 0; held[k] = 0; gap_left[k] = 0;
            in_gap[k] = 1'b0; last_p2[k] = 1'b1; exp_m[k] = 1'b0;
        end

        // reset with P1 already requesting, then P1 alone through timeouts
        run_cycle(1'b1, 1'b0, 1'b0);
        run_cycle(1'b1, 1'b1, 1'b0);
        repeat (25) run_cycle(1'b0, 1'b1, 1'b0);
        repeat (4)  run_cycle(1'b0, 1'b0, 1'b0);

        // short voluntary grant
        repeat (3) run_cycle(1'b0, 1'b1, 1'b0);
        repeat (4) run_cycle(1'b0, 1'b0, 1'b0);

        // simultaneous requests after reset, P1 drops early
        run_cycle(1'b1, 1'b0, 1'b0);
        repeat (2) run_cycle(1'b0, 1'b1, 1'b1);
        repeat (6) run_cycle(1'b0, 1'b0, 1'b1);

        // continuous contention
        repeat (45) run_cycle(1'b0, 1'b1, 1'b1);

        // reset mid-grant of P2, then P2 keeps requesting
        run_cycle(1'b1, 1'b0, 1'b0);
        repeat (4)  run_cycle(1'b0, 1'b0, 1'b1);
        run_cycle(1'b1, 1'b0, 1'b1);
        repeat (12) run_cycle(1'b0, 1'b0, 1'b1);

        // random levels that toggle rarely, occasional reset
        a = 1'b0; b = 1'b0;
        repeat (2000) begin
            if ($urandom_range(7) == 0) a = ~a;
            if ($urandom_range(7) == 0) b = ~b;
            run_cycle($urandom_range(99) == 0, a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
